// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RV32I subset core: fetch/decode/execute/memory/writeback sequencing.
// Optional macro MC_ADDI_EN adds the addi execute state (S_EXECI, encoding 10).
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] Aluop,
  output logic       illegal_instr,
  output logic [3:0] state
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
`ifdef MC_ADDI_EN
  localparam logic [6:0] OP_ADDI = 7'b0010011;
`endif

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECR    = 4'd7,
    S_ALUWB    = 4'd8,
`ifdef MC_ADDI_EN
    S_EXECI    = 4'd10,
`endif
    S_BEQ      = 4'd9
  } state_t;

  state_t state_q, state_d;

  // Async reset so a pending memory request is withdrawn without waiting for a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = S_FETCH;
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    Aluop         = 2'b00;
    illegal_instr = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        state_d    = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_BEQ:       state_d = S_BEQ;
`ifdef MC_ADDI_EN
          OP_ADDI:      state_d = S_EXECI;
`endif
          default: begin
            illegal_instr = 1'b1;
            state_d       = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        state_d   = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        Aluop     = 2'b10;
        state_d   = S_ALUWB;
      end
`ifdef MC_ADDI_EN
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = S_ALUWB;
      end
`endif
      S_ALUWB: reg_write = 1'b1;
      S_BEQ: begin
        alu_src_a = 2'b10;
        Aluop     = 2'b01;
        pc_write  = zero;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-instruction expected state traces with random memory waits.
module tb_multicycle_control;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal_instr;
  logic [1:0] result_src, alu_src_a, alu_src_b, Aluop;
  logic [3:0] state;
  logic [14:0] obs;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0] st;
    logic       rdy;
  } step_t;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .Aluop(Aluop),
    .illegal_instr(illegal_instr), .state(state)
  );

  always #5 clk = ~clk;

  assign obs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                result_src, alu_src_a, alu_src_b, Aluop, illegal_instr};

  // Output table per state, straight from the state descriptions.
  function automatic logic [14:0] exp_out(input logic [3:0] st, input logic rdy,
                                          input logic z, input logic ill);
    logic mreq, mwr, adr, irw, pcw, rw, il;
    logic [1:0] rs, sa, sb, aop;
    {mreq, mwr, adr, irw, pcw, rw, il} = '0;
    {rs, sa, sb, aop} = '0;
    case (st)
      4'd1: begin mreq = 1; sb = 2'b10; rs = 2'b10; irw = rdy; pcw = rdy; end
      4'd2: begin sa = 2'b01; sb = 2'b01; il = ill; end
      4'd3: begin sa = 2'b10; sb = 2'b01; end
      4'd4: begin mreq = 1; adr = 1; end
      4'd5: begin rs = 2'b01; rw = 1; end
      4'd6: begin mreq = 1; mwr = 1; adr = 1; end
      4'd7: begin sa = 2'b10; sb = 2'b00; aop = 2'b10; end
      4'd8: begin rw = 1; end
      4'd9: begin sa = 2'b10; aop = 2'b01; pcw = z; end
      4'd10: begin
`ifdef MC_ADDI_EN
        sa = 2'b10; sb = 2'b01;
`endif
      end
      default: ;
    endcase
    return {mreq, mwr, adr, irw, pcw, rw, rs, sa, sb, aop, il};
  endfunction

  // Builds the expected state trace of one instruction and walks it cycle by cycle.
  // abort_at >= 0 asserts reset asynchronously in that step.
  task automatic exec_instr(input string name, input logic [6:0] op, input int wf,
                            input int wm, input logic z, input int abort_at);
    step_t q[$];
    logic ill;
    logic [14:0] e;
    ill = 1'b0;
    for (int i = 0; i < wf; i++) q.push_back({4'd1, 1'b0});
    q.push_back({4'd1, 1'b1});
    q.push_back({4'd2, 1'($urandom)});
    case (op)
      OP_LW: begin
        q.push_back({4'd3, 1'($urandom)});
        for (int i = 0; i < wm; i++) q.push_back({4'd4, 1'b0});
        q.push_back({4'd4, 1'b1});
        q.push_back({4'd5, 1'($urandom)});
      end
      OP_SW: begin
        q.push_back({4'd3, 1'($urandom)});
        for (int i = 0; i < wm; i++) q.push_back({4'd6, 1'b0});
        q.push_back({4'd6, 1'b1});
      end
      OP_R: begin
        q.push_back({4'd7, 1'($urandom)});
        q.push_back({4'd8, 1'($urandom)});
      end
      OP_BEQ: q.push_back({4'd9, 1'($urandom)});
`ifdef MC_ADDI_EN
      OP_ADDI: begin
        q.push_back({4'd10, 1'($urandom)});
        q.push_back({4'd8, 1'($urandom)});
      end
`endif
      default: ill = 1'b1;
    endcase
    foreach (q[i]) begin
      @(negedge clk);
      opcode = op; zero = z; mem_ready = q[i].rdy;
      #1;
      checks++;
      if (state !== q[i].st) begin
        failures++;
        $display("FAIL %s step%0d state got=%0d want=%0d", name, i, state, q[i].st);
      end
      e = exp_out(q[i].st, q[i].rdy, z, ill);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL %s step%0d outputs got=%b want=%b", name, i, obs, e);
      end
      if (i == abort_at) begin
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({state, mem_req, mem_write} !== 6'd0) begin
          failures++;
          $display("FAIL %s async_reset state=%0d mem_req=%b mem_write=%b want 0", name, state, mem_req, mem_write);
        end
        checks++;
        if (obs !== 15'd0) begin
          failures++;
          $display("FAIL %s async_reset outputs got=%b want=0", name, obs);
        end
        @(negedge clk);
        reset = 1'b0;
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; opcode = 7'd0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || obs !== 15'd0) begin
      failures++;
      $display("FAIL reset_idle state=%0d outputs=%b want state=0 outputs=0", state, obs);
    end
    @(negedge clk);
    #1;
    checks++;
    if (state !== 4'd1 || obs !== exp_out(4'd1, 1'b0, 1'b0, 1'b0)) begin
      failures++;
      $display("FAIL reset_to_fetch state=%0d outputs=%b want state=1 outputs=%b", state, obs,
               exp_out(4'd1, 1'b0, 1'b0, 1'b0));
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (state !== 4'd0 || obs !== 15'd0) begin
      failures++;
      $display("FAIL reset_in_fetch state=%0d outputs=%b want state=0 outputs=0", state, obs);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0) begin
      failures++;
      $display("FAIL reset_release state=%0d want=0", state);
    end
  endtask

  task automatic test_lw();
    exec_instr("lw_wait", OP_LW, 2, 2, 1'b0, -1);
    exec_instr("lw_nowait", OP_LW, 0, 0, 1'b1, -1);
  endtask

  task automatic test_sw();
    exec_instr("sw", OP_SW, 1, 1, 1'b0, -1);
  endtask

  task automatic test_rtype();
    exec_instr("rtype", OP_R, 0, 0, 1'b1, -1);
  endtask

  task automatic test_beq();
    exec_instr("beq_taken", OP_BEQ, 0, 0, 1'b1, -1);
    exec_instr("beq_not_taken", OP_BEQ, 0, 0, 1'b0, -1);
  endtask

  task automatic test_illegal();
    exec_instr("illegal_7f", 7'b1111111, 0, 0, 1'b0, -1);
    exec_instr("addi_opcode", OP_ADDI, 0, 0, 1'b0, -1);
  endtask

  task automatic test_sw_reset();
    // Steps: fetch, decode, memadr, first memwrite wait.
    exec_instr("sw_reset", OP_SW, 0, 3, 1'b0, 3);
  endtask

  task automatic test_random();
    logic [6:0] op;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 5))
        0: op = OP_LW;
        1: op = OP_SW;
        2: op = OP_R;
        3: op = OP_BEQ;
        4: op = OP_ADDI;
        default: op = 7'($urandom);
      endcase
      exec_instr("random", op, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom), -1);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_rtype();
    test_beq();
    test_illegal();
    test_sw_reset();
    test_lw();
    test_random();
    @(negedge clk);
    #1;
    checks++;
    if (state !== 4'd1) begin
      failures++;
      $display("FAIL final_fetch state=%0d want=1", state);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
